// File: rtl/section_sequencer_pkg.sv
// Shared types and widths for the section sequencer and its neighbours.
package section_sequencer_pkg;

    localparam int NUM_LANES = 30;
    localparam int SECT_W    = 4;
    localparam int CORNER_W  = 18;
    localparam int RES_W     = 9;
    localparam int NSECT_W   = 5;

    // Largest section count a run may request; larger requests are clamped.
    localparam logic [NSECT_W-1:0] MAX_SECT = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Clamp a requested section count so the 4-bit section index never wraps.
    function automatic logic [NSECT_W-1:0] sat_num_sect(input logic [NSECT_W-1:0] n);
        return (n > MAX_SECT) ? MAX_SECT : n;
    endfunction

endpackage

// File: rtl/section_sequencer_if.sv
// Control/data bundle between a frame requester and the section sequencer.
interface section_sequencer_if #(
    parameter int NUM_LANES = section_sequencer_pkg::NUM_LANES
);
    import section_sequencer_pkg::*;

    logic                 start;
    logic                 abort;
    logic [CORNER_W-1:0]  corner_b_in;
    logic [RES_W-1:0]     res_in;
    logic [NSECT_W-1:0]   num_sect;
    logic [NUM_LANES-1:0] lane_done;

    logic [CORNER_W-1:0]  corner_b;
    logic [RES_W-1:0]     res;
    logic [SECT_W-1:0]    sectnum;
    logic                 load;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, abort, corner_b_in, res_in, num_sect, lane_done,
        input  corner_b, res, sectnum, load, busy, done, err
    );

    modport slave (
        input  start, abort, corner_b_in, res_in, num_sect, lane_done,
        output corner_b, res, sectnum, load, busy, done, err
    );

endinterface

// File: rtl/section_sequencer.sv
// Frame sequencer: steps through the requested sections, strobing the lanes
// to load once per section and waiting for every lane to report completion,
// with a watchdog that aborts the run if the lanes stall.
module section_sequencer #(
    parameter int NUM_LANES = section_sequencer_pkg::NUM_LANES,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clk,
    input  logic               n_rst,
    section_sequencer_if.slave bus
);
    import section_sequencer_pkg::*;

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [SECT_W-1:0]    sectnum_r;
    logic [SECT_W-1:0]    sectnum_nxt_s;
    logic [NSECT_W-1:0]   nsect_r;
    logic [CORNER_W-1:0]  corner_b_r;
    logic [RES_W-1:0]     res_r;
    logic                 load_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;
    logic                 latch_s;
    logic                 done_nxt_s;
    logic                 err_nxt_s;
    logic [NUM_LANES-1:0] lane_done_s;
    logic                 all_done_s;

    assign lane_done_s = bus.lane_done;
    assign all_done_s  = &lane_done_s;

    // Next-state, watchdog counter and section index; abort outranks everything outside IDLE.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        sectnum_nxt_s = sectnum_r;
        latch_s       = 1'b0;
        done_nxt_s    = 1'b0;
        err_nxt_s     = 1'b0;
        if ((state_r != ST_IDLE) && bus.abort) begin
            state_nxt_s   = ST_IDLE;
            sectnum_nxt_s = {SECT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        latch_s       = 1'b1;
                        sectnum_nxt_s = {SECT_W{1'b0}};
                        state_nxt_s   = (bus.num_sect == 5'd0) ? ST_FINISH : ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (all_done_s) begin
                        state_nxt_s = ST_NEXT;
                    end else if (cnt_r == CNT_MAX) begin
                        err_nxt_s     = 1'b1;
                        sectnum_nxt_s = {SECT_W{1'b0}};
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if ({1'b0, sectnum_r} == (nsect_r - 5'd1)) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        sectnum_nxt_s = sectnum_r + 4'd1;
                        state_nxt_s   = ST_LOAD;
                    end
                end
                ST_FINISH: begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    sectnum_nxt_s = {SECT_W{1'b0}};
                    state_nxt_s   = ST_IDLE;
                end
            endcase
        end
    end

    // State register, latched frame parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            sectnum_r  <= {SECT_W{1'b0}};
            nsect_r    <= {NSECT_W{1'b0}};
            corner_b_r <= {CORNER_W{1'b0}};
            res_r      <= {RES_W{1'b0}};
            load_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sectnum_r <= sectnum_nxt_s;
            if (latch_s) begin
                corner_b_r <= bus.corner_b_in;
                res_r      <= bus.res_in;
                nsect_r    <= sat_num_sect(bus.num_sect);
            end
            load_r <= (state_nxt_s == ST_LOAD);
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= done_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign bus.corner_b = corner_b_r;
    assign bus.res      = res_r;
    assign bus.sectnum  = sectnum_r;
    assign bus.load     = load_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: doc/section_sequencer.md
SECTION_SEQUENCER -- requirements
Module: section_sequencer

Interface
REQ-001 Parameter NUM_LANES, default 30: number of lane units loaded per section.
REQ-002 Parameter TIMEOUT, default 1023: maximum WAIT cycles before an error abort.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 n_rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a frame run; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current run.
REQ-007 corner_b_in  input  18  frame corner value.
REQ-008 res_in  input  9  per-lane step.
REQ-009 num_sect  input  5  number of sections to run, 0..16.
REQ-010 lane_done  input  NUM_LANES  per-lane completion flags.
REQ-011 corner_b  output  18  latched corner value, driven to the lane-value calculator.
REQ-012 res  output  9  latched step, driven to the lane-value calculator.
REQ-013 sectnum  output  4  current section index.
REQ-014 load  output  1  one-cycle strobe: lanes capture calculator outputs.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  one-cycle pulse on timeout.

Function
REQ-018 States: IDLE, LOAD, WAIT, NEXT, FINISH; all outputs registered.
REQ-019 IDLE with start=1: latch corner_b_in, res_in and num_sect; sectnum<=0; go to LOAD; start is ignored in all other states.
REQ-020 IDLE with start=1 and num_sect=0: go to FINISH directly; load is never asserted.
REQ-021 LOAD: load=1 for exactly that one cycle; go to WAIT; clear the timeout counter.
REQ-022 WAIT: sample lane_done only in WAIT; lane_done in LOAD is ignored.
REQ-023 WAIT with &lane_done=1: go to NEXT.
REQ-024 WAIT with the counter reaching TIMEOUT: err=1 for one cycle; go to IDLE; sectnum<=0; done is not pulsed.
REQ-025 NEXT with sectnum==latched num_sect-1: go to FINISH.
REQ-026 NEXT otherwise: sectnum<=sectnum+1; go to LOAD.
REQ-027 num_sect values above 16 saturate to 16, so sectnum never wraps past 15.
REQ-028 FINISH: done=1 for one cycle; go to IDLE. Result: done occurs exactly once per successful run.
REQ-029 abort=1 in any non-IDLE state: go to IDLE next cycle; sectnum<=0; no done or err.
REQ-030 abort has priority over every other transition in the same cycle; abort in IDLE has no effect.
REQ-031 abort=1 and start=1 together in IDLE: start wins.
REQ-032 corner_b, res and num_sect stay stable from latch until return to IDLE, whatever happens on their inputs.
REQ-033 Minimum section period is 3 cycles: LOAD, one WAIT cycle, NEXT.

Reset
REQ-034 n_rst=0 at a clock edge: state<=IDLE; sectnum, corner_b, res, load, done, err and the counter <=0; busy=0.
REQ-035 Reset mid-run discards the run without a done or err pulse.

Structure
REQ-036 A shared package holds the state enum, NUM_LANES, SECT_W=4, and the widths 18 and 9.
REQ-037 No sub-module is required: one FSM plus a timeout counter.
REQ-038 The lane-value calculator (initial_calculator) is instantiated at the parent level and driven by sectnum, corner_b and res.

Verification
REQ-039 start, num_sect=3, lane_done all-ones 2 cycles after each load -> sectnum 0,1,2; three load pulses; one done; busy falls with done.
REQ-040 start with num_sect=0 -> no load; done 2 cycles after start.
REQ-041 lane_done missing bit 29 forever, TIMEOUT=15 -> one err 16 WAIT cycles after load; back to IDLE; sectnum=0.
REQ-042 abort during WAIT of section 1 of 4 -> IDLE next cycle; no done; a new start runs from sectnum=0.
REQ-043 lane_done all-ones held during LOAD -> no premature advance; WAIT still lasts at least 1 cycle.
REQ-044 n_rst=0 mid-run, then start with corner_b_in=1000 and res_in=2 -> all outputs zero during reset; outputs corner_b=1000, res=2; inputs changed mid-run leave outputs unchanged.
